// File: rtl/mux_pipe_reg.sv
// mux_pipe_reg: N-way registered selector with valid/stall/flush; MUXPIPE_ERR_EN builds the out-of-range select error pulse and counter.
module mux_pipe_reg #(
  parameter int K = 32,
  parameter int N = 4,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*K-1:0] din_i,
  input  logic [SW-1:0]  sel_i,
  input  logic           valid_i,
  input  logic           stall_i,
  input  logic           flush_i,
  output logic [K-1:0]   data_o,
  output logic           valid_o,
  output logic           err_o,
  output logic [7:0]     err_cnt_o
);
  logic [K-1:0] w_data;
  logic         w_ok;
  logic         w_take;
  logic [K-1:0] r_data;
  logic         r_valid;
  assign w_ok   = int'(sel_i) < N;
  assign w_take = valid_i & w_ok;
  // AND-OR decode keeps every channel an equal-depth path
  always_comb begin
    w_data = '0;
    for (int c = 0; c < N; c++) w_data = w_data | (din_i[c*K +: K] & {K{sel_i == SW'(c)}});
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (flush_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (!stall_i) begin
      r_valid <= w_take;
      if (w_take) r_data <= w_data;
    end
  assign data_o  = r_data;
  assign valid_o = r_valid;
`ifdef MUXPIPE_ERR_EN
  logic       w_bad;
  logic       r_err;
  logic [7:0] r_cnt;
  assign w_bad = valid_i & ~w_ok & ~stall_i & ~flush_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_err <= 1'b0;
      r_cnt <= 8'd0;
    end else begin
      r_err <= w_bad;
      if (w_bad && r_cnt != 8'hff) r_cnt <= r_cnt + 8'd1;
    end
  assign err_o     = r_err;
  assign err_cnt_o = r_cnt;
`else
  assign err_o     = 1'b0;
  assign err_cnt_o = 8'd0;
`endif
endmodule
